add16_seq: RTL and testbench
============================

ADD16_SEQ -- requirements
Module: add16_seq

Interface
REQ-001: Parameter WIDTH, default 16, is the operand width in bits and SHALL be a multiple of 4.
REQ-002: Parameter SLICE, default 4, is the adder slice width in bits per cycle and SHALL be fixed at 4.
REQ-003: clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004: rst  input  1  reset, synchronous and active-high.
REQ-005: in_valid  input  1  the operand set is presented.
REQ-006: in_ready  output  1  the block can accept an operand set.
REQ-007: a  input  WIDTH  operand A.
REQ-008: b  input  WIDTH  operand B.
REQ-009: c  input  1  carry-in.
REQ-010: out_valid  output  1  sum and carry hold a completed result.
REQ-011: out_ready  input  1  the consumer takes the result.
REQ-012: sum  output  WIDTH  result bits.
REQ-013: carry  output  1  carry-out of the most significant slice.
REQ-014: busy  output  1  high in states RUN and DONE.

Function
REQ-015: The FSM SHALL have three states, IDLE, RUN and DONE; in_ready SHALL equal (state==IDLE).
REQ-016: An operand set SHALL be accepted on an edge where in_valid and in_ready are both high; a, b and c SHALL be captured into internal registers, the slice index SHALL be set to 0, and the state SHALL go to RUN.
REQ-017: In RUN, each cycle SHALL add slice i of the captured A and B plus the running carry (c for i=0), write the result into sum[4i+3:4i], update the running carry, and increment i.
REQ-018: After the slice with i=WIDTH/4-1 completes, the FSM SHALL go to DONE, so out_valid rises exactly WIDTH/4 cycles after acceptance (4 cycles at default).
REQ-019: In DONE, out_valid SHALL be 1 and sum and carry SHALL be stable until an edge with out_ready=1; that edge SHALL return the FSM to IDLE.
REQ-020: A new operand set SHALL NOT be accepted on the edge that leaves DONE; the minimum issue interval is WIDTH/4+2 cycles.
REQ-021: in_valid and changes on a, b or c SHALL be ignored during RUN and DONE.
REQ-022: sum and carry SHALL keep the last result in IDLE until the next acceptance, which clears carry at the first RUN edge.
REQ-023: Arithmetic SHALL be unsigned modulo 2^WIDTH with carry = bit WIDTH of a+b+c; there is no overflow flag.
REQ-024: out_valid SHALL be high only in DONE; busy SHALL be low only in IDLE.

Reset
REQ-025: On an edge with rst=1 in any state, the FSM SHALL go to IDLE, and sum, carry, the slice index and the captured operands SHALL be set to 0.
REQ-026: Reset mid-RUN or mid-DONE SHALL drop the operation; out_valid SHALL be 0 in the cycle after reset.
REQ-027: rst SHALL take priority over in_valid and out_ready on the same edge.

Structure
REQ-028: Package add16_pkg SHALL hold the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2), the SLICE constant and the slice-index width.
REQ-029: The per-cycle add SHALL be one instance of a combinational 4-bit ripple-carry sub-module nibble_add (ports x, y, ci, s, co) built from full adders.
REQ-030: There SHALL be no other arithmetic in add16_seq beyond the slice-index increment.

Verification
REQ-031: a=0x1234, b=0x4321, c=0 -> sum=0x5555, carry=0, with out_valid exactly 4 cycles after acceptance.
REQ-032: a=0xFFFF, b=0x0001, c=0 -> sum=0x0000, carry=1; and a=0xFFFF, b=0xFFFF, c=1 -> sum=0xFFFF, carry=1.
REQ-033: Back-pressure: out_ready held low for 3 cycles in DONE -> sum, carry and out_valid held; release -> IDLE next cycle, in_ready=1.
REQ-034: in_valid held high with a=0x0F0F changing during RUN -> the result reflects only the operands captured at acceptance, with in_ready=0 throughout.
REQ-035: rst asserted during the 2nd RUN cycle -> the next cycle shows IDLE, out_valid=0, sum=0, carry=0; a following operation (0x0008+0x0008, c=1) -> 0x0011, carry=0.
REQ-036: A random back-to-back stream of 1000 operations -> every result matches a+b+c with the required latency, and no transfer is lost or duplicated.

Source files
------------

// File: rtl/add16_pkg.sv
// Shared definitions for the slice-serial adder: FSM encoding, slice width
// and the slice-index width helper.
package add16_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int SLICE_W = 4;

   function automatic int idx_width(input int width);
      int nib;
      nib = width / SLICE_W;
      return (nib > 1) ? $clog2(nib) : 1;
   endfunction

   localparam int IDX_W = idx_width(16);

endpackage

// File: rtl/nibble_add.sv
// Combinational 4-bit ripple-carry adder built from a chain of full adders.
module nibble_add (
   input  logic [3:0] x,
   input  logic [3:0] y,
   input  logic       ci,
   output logic [3:0] s,
   output logic       co
);

   logic [4:0] c_s;

   assign c_s[0] = ci;

   for (genvar k = 0; k < 4; k++) begin : g_fa
      assign s[k]     = x[k] ^ y[k] ^ c_s[k];
      assign c_s[k+1] = (x[k] & y[k]) | (c_s[k] & (x[k] ^ y[k]));
   end

   assign co = c_s[4];

endmodule

// File: rtl/add16_seq.sv
// Slice-serial adder: captures a+b+c on acceptance, adds one 4-bit slice per
// cycle, then holds the result in DONE until the consumer takes it.
module add16_seq
   import add16_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             busy
);

   localparam int NIB = WIDTH / SLICE;
   localparam int IW  = idx_width(WIDTH);

   state_e           state_q, state_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             rc_q, rc_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;

   logic [3:0]       nib_x_s, nib_y_s, nib_s_s;
   logic             nib_co_s;

   // Route the slice selected by the index to the nibble adder.
   always_comb begin
      nib_x_s = 4'd0;
      nib_y_s = 4'd0;
      for (int k = 0; k < NIB; k++) begin
         nib_x_s = (idx_q == IW'(k)) ? a_q[k*SLICE +: SLICE] : nib_x_s;
         nib_y_s = (idx_q == IW'(k)) ? b_q[k*SLICE +: SLICE] : nib_y_s;
      end
   end

   nibble_add u_nibble_add (
      .x  (nib_x_s),
      .y  (nib_y_s),
      .ci (rc_q),
      .s  (nib_s_s),
      .co (nib_co_s)
   );

   // Next-state and datapath update logic.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      rc_d    = rc_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               rc_d    = c;
               idx_d   = '0;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            for (int k = 0; k < NIB; k++) begin
               sum_d[k*SLICE +: SLICE] = (idx_q == IW'(k)) ? nib_s_s : sum_q[k*SLICE +: SLICE];
            end
            rc_d  = nib_co_s;
            idx_d = idx_q + IW'(1);
            // carry only becomes visible once the top slice has been added
            if (idx_q == IW'(NIB - 1)) begin
               carry_d = nib_co_s;
               state_d = DONE;
            end else begin
               carry_d = 1'b0;
               state_d = RUN;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         rc_q    <= 1'b0;
         sum_q   <= '0;
         carry_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         rc_q    <= rc_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign sum       = sum_q;
   assign carry     = carry_q;

endmodule

// File: tb/tb_add16_seq.sv
// Self-checking bench for add16_seq: directed scenarios plus a random
// back-to-back stream checked against a plain a+b+c reference.
module tb_add16_seq;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        c;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] sum;
   logic        carry;
   logic        busy;

   int n_checks;
   int n_pass;

   add16_seq #(.WIDTH(16), .SLICE(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .c         (c),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .carry     (carry),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [16:0] ref_add(input logic [15:0] x, input logic [15:0] y, input logic ci);
      return {1'b0, x} + {1'b0, y} + {16'd0, ci};
   endfunction

   // Present one operand set, then count rising edges until out_valid (lat=-1 on timeout).
   task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                        output int lat, output logic [15:0] rs, output logic rc);
      @(negedge clk);
      in_valid = 1'b1; a = ta; b = tb_; c = tc;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      a = 16'($urandom); b = 16'($urandom); c = 1'($urandom);
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (out_valid) begin
            lat = i;
            break;
         end
      end
      rs = sum;
      rc = carry;
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = 16'd0; b = 16'd0; c = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
      n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
      n_checks++; if (sum !== 16'h0000) $display("FAIL reset_sum: got %h want 0000", sum); else n_pass++;
      n_checks++; if (carry !== 1'b0) $display("FAIL reset_carry: got %b want 0", carry); else n_pass++;
   endtask

   task automatic test_basic();
      int lat; logic [15:0] rs; logic rc;
      do_op(16'h1234, 16'h4321, 1'b0, lat, rs, rc);
      n_checks++; if (lat !== 4) $display("FAIL basic_latency: got %0d want 4", lat); else n_pass++;
      n_checks++; if (rs !== 16'h5555) $display("FAIL basic_sum: got %h want 5555", rs); else n_pass++;
      n_checks++; if (rc !== 1'b0) $display("FAIL basic_carry: got %b want 0", rc); else n_pass++;
      n_checks++; if (busy !== 1'b1) $display("FAIL basic_busy_done: got %b want 1", busy); else n_pass++;
      consume();
   endtask

   task automatic test_boundary();
      int lat; logic [15:0] rs; logic rc;
      do_op(16'hFFFF, 16'h0001, 1'b0, lat, rs, rc);
      n_checks++; if (lat !== 4) $display("FAIL wrap_latency: got %0d want 4", lat); else n_pass++;
      n_checks++; if (rs !== 16'h0000) $display("FAIL wrap_sum: got %h want 0000", rs); else n_pass++;
      n_checks++; if (rc !== 1'b1) $display("FAIL wrap_carry: got %b want 1", rc); else n_pass++;
      consume();
      do_op(16'hFFFF, 16'hFFFF, 1'b1, lat, rs, rc);
      n_checks++; if (lat !== 4) $display("FAIL max_latency: got %0d want 4", lat); else n_pass++;
      n_checks++; if (rs !== 16'hFFFF) $display("FAIL max_sum: got %h want ffff", rs); else n_pass++;
      n_checks++; if (rc !== 1'b1) $display("FAIL max_carry: got %b want 1", rc); else n_pass++;
      consume();
   endtask

   task automatic test_backpressure();
      int lat; logic [15:0] rs; logic rc; logic [16:0] exp;
      exp = ref_add(16'hA5C3, 16'h3C5A, 1'b1);
      do_op(16'hA5C3, 16'h3C5A, 1'b1, lat, rs, rc);
      n_checks++; if ({rc, rs} !== exp) $display("FAIL bp_result: got %h want %h", {rc, rs}, exp); else n_pass++;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         @(negedge clk);
         n_checks++; if (out_valid !== 1'b1) $display("FAIL bp_hold_valid: got %b want 1", out_valid); else n_pass++;
         n_checks++; if ({carry, sum} !== exp) $display("FAIL bp_hold_result: got %h want %h", {carry, sum}, exp); else n_pass++;
      end
      consume();
      n_checks++; if (in_ready !== 1'b1) $display("FAIL bp_release_in_ready: got %b want 1", in_ready); else n_pass++;
      n_checks++; if (out_valid !== 1'b0) $display("FAIL bp_release_out_valid: got %b want 0", out_valid); else n_pass++;
      repeat (2) @(negedge clk);
      n_checks++; if ({carry, sum} !== exp) $display("FAIL idle_keeps_result: got %h want %h", {carry, sum}, exp); else n_pass++;
   endtask

   task automatic test_ignore_inputs();
      int lat; logic [16:0] exp;
      exp = ref_add(16'h0F0F, 16'h1111, 1'b0);
      @(negedge clk);
      in_valid = 1'b1; a = 16'h0F0F; b = 16'h1111; c = 1'b0;
      @(posedge clk);
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         n_checks++; if (in_ready !== 1'b0) $display("FAIL ignore_in_ready: got %b want 0 at cycle %0d", in_ready, i); else n_pass++;
         a = 16'($urandom); b = 16'($urandom); c = 1'($urandom);
         @(posedge clk);
         @(negedge clk);
         if (out_valid) begin
            lat = i;
            break;
         end
         @(posedge clk);
      end
      in_valid = 1'b0;
      n_checks++; if (lat < 0) $display("FAIL ignore_timeout: got no out_valid want result"); else n_pass++;
      n_checks++; if ({carry, sum} !== exp) $display("FAIL ignore_result: got %h want %h", {carry, sum}, exp); else n_pass++;
      consume();
   endtask

   task automatic test_reset_mid_run();
      int lat; logic [15:0] rs; logic rc;
      @(negedge clk);
      in_valid = 1'b1; a = 16'hBEEF; b = 16'h1357; c = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      n_checks++; if (in_ready !== 1'b1) $display("FAIL midrst_idle: got in_ready %b want 1", in_ready); else n_pass++;
      n_checks++; if (out_valid !== 1'b0) $display("FAIL midrst_out_valid: got %b want 0", out_valid); else n_pass++;
      n_checks++; if (sum !== 16'h0000) $display("FAIL midrst_sum: got %h want 0000", sum); else n_pass++;
      n_checks++; if (carry !== 1'b0) $display("FAIL midrst_carry: got %b want 0", carry); else n_pass++;
      do_op(16'h0008, 16'h0008, 1'b1, lat, rs, rc);
      n_checks++; if (lat !== 4) $display("FAIL postrst_latency: got %0d want 4", lat); else n_pass++;
      n_checks++; if (rs !== 16'h0011) $display("FAIL postrst_sum: got %h want 0011", rs); else n_pass++;
      n_checks++; if (rc !== 1'b0) $display("FAIL postrst_carry: got %b want 0", rc); else n_pass++;
      consume();
   endtask

   // in_valid stays high and out_ready stays high; each accepted operand set is
   // queued with the negedge index before its acceptance edge. out_valid is seen
   // at the negedge 5 later (acceptance edge + 4 slice edges).
   task automatic test_back_to_back();
      logic [16:0] exp_q[$];
      int          cyc_q[$];
      int          accepted, received, errs, cyc;
      logic [16:0] exp;
      int          acyc;
      accepted = 0; received = 0; errs = 0; cyc = 0;
      out_ready = 1'b1;
      while (received < 1000 && cyc < 20000) begin
         @(negedge clk);
         cyc++;
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               errs++;
               if (errs <= 5) $display("FAIL b2b_spurious: got result %h want none pending", {carry, sum});
            end else begin
               exp  = exp_q.pop_front();
               acyc = cyc_q.pop_front();
               if ({carry, sum} !== exp || (cyc - acyc) != 5) begin
                  errs++;
                  if (errs <= 5) $display("FAIL b2b_result: got %h after %0d want %h after 5", {carry, sum}, cyc - acyc, exp);
               end
            end
            received++;
         end
         in_valid = (accepted < 1000);
         a = 16'($urandom); b = 16'($urandom); c = 1'($urandom);
         if (in_valid && in_ready) begin
            exp_q.push_back(ref_add(a, b, c));
            cyc_q.push_back(cyc);
            accepted++;
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      n_checks++; if (errs != 0) $display("FAIL b2b_errors: got %0d errors want 0", errs); else n_pass++;
      n_checks++; if (accepted != 1000) $display("FAIL b2b_accepted: got %0d want 1000", accepted); else n_pass++;
      n_checks++; if (received != 1000) $display("FAIL b2b_received: got %0d want 1000", received); else n_pass++;
      n_checks++; if (exp_q.size() != 0) $display("FAIL b2b_leftover: got %0d pending want 0", exp_q.size()); else n_pass++;
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      test_reset();
      test_basic();
      test_boundary();
      test_backpressure();
      test_ignore_inputs();
      test_reset_mid_run();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
